// File: rtl/gemm_result_writer.sv
// gemm_result_writer: buffers up to two 4x4 result tiles and drains them row by row into the output SRAM
module gemm_result_writer #(
    parameter int AddrWidth = 16,
    parameter int OutWidth  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   M_size_i,
    input  logic [AddrWidth-1:0]   N_size_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic                   result_valid_i,
    input  logic [16*OutWidth-1:0] result_i,
    output logic                   result_ready_o,
    output logic                   sram_wr_req_o,
    input  logic                   sram_wr_gnt_i,
    output logic [AddrWidth-1:0]   sram_addr_o,
    output logic [4*OutWidth-1:0]  sram_wdata_o,
    output logic                   busy_o,
    output logic                   done_o
);
    typedef enum logic [1:0] {Idle, Active, Finish} state_e;
    state_e state_q, state_d;
    logic [AddrWidth-1:0] tm_max_q, tn_max_q, base_q, tm_q, tn_q, addr;
    logic [1:0] r_q, cnt_q;
    logic [16*OutWidth-1:0] mem_q [2];
    logic [16*OutWidth-1:0] head;
    logic rd_ptr_q, wr_ptr_q, push, pop, wr, zero_grid, last_tile, tn_wrap;
    assign zero_grid = tm_max_q == '0 || tn_max_q == '0;
    assign result_ready_o = state_q == Active && cnt_q != 2'd2;
    assign push = result_valid_i && result_ready_o;
    assign sram_wr_req_o = state_q == Active && !zero_grid && cnt_q != 2'd0;
    assign wr = sram_wr_req_o && sram_wr_gnt_i;
    assign pop = wr && r_q == 2'd3;
    assign tn_wrap = tn_q == tn_max_q - AddrWidth'(1);
    assign last_tile = tn_wrap && tm_q == tm_max_q - AddrWidth'(1);
    assign head = mem_q[rd_ptr_q];
    assign addr = base_q + ((tm_q << 2) + AddrWidth'(r_q)) * tn_max_q + tn_q;
    assign sram_addr_o = sram_wr_req_o ? addr : '0;
    assign sram_wdata_o = sram_wr_req_o ? head[r_q*4*OutWidth +: 4*OutWidth] : '0;
    assign busy_o = state_q != Idle;
    assign done_o = state_q == Finish;
    always_comb begin
        state_d = state_q;
        state_d = state_q == Idle   ? (start_i ? Active : Idle) :
                  state_q == Active ? ((zero_grid || (pop && last_tile)) ? Finish : Active) : Idle;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            tm_max_q <= '0;
            tn_max_q <= '0;
            base_q   <= '0;
            tm_q     <= '0;
            tn_q     <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == Idle && start_i) begin
                tm_max_q <= M_size_i >> 2;
                tn_max_q <= N_size_i >> 2;
                base_q   <= base_addr_i;
                tm_q     <= '0;
                tn_q     <= '0;
                r_q      <= '0;
            end
            if (wr) r_q <= r_q + 2'd1;
            if (pop) begin
                tn_q <= tn_wrap ? '0 : tn_q + AddrWidth'(1);
                if (tn_wrap) tm_q <= tm_q + AddrWidth'(1);
            end
            // Finish drops any surplus tiles so the next run starts empty
            if (state_q == Finish) begin
                cnt_q    <= '0;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 2'(push) - 2'(pop);
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop) rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= result_i;
    end
endmodule

// File: tb/tb_gemm_result_writer.sv
// tb_gemm_result_writer: directed table-driven checks of tile placement, backpressure, zero size and reset abort
module tb_gemm_result_writer;
    localparam int AW = 16;
    localparam int OW = 32;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0, gnt = 1'b0;
    logic [AW-1:0] m_size = '0, n_size = '0, base = '0;
    logic [16*OW-1:0] result = '0;
    logic ready, req, busy, done;
    logic [AW-1:0] addr;
    logic [4*OW-1:0] wdata;
    int cyc = 0, n_chk = 0, n_fail = 0, done_cnt = 0, done_cyc = 0;
    typedef struct {logic [AW-1:0] addr; logic [4*OW-1:0] data; int cyc;} wr_t;
    typedef struct {int k; int r; logic [AW-1:0] addr;} vec_t;
    wr_t wr_q[$];

    gemm_result_writer #(.AddrWidth(AW), .OutWidth(OW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .M_size_i(m_size), .N_size_i(n_size),
        .base_addr_i(base), .result_valid_i(valid), .result_i(result), .result_ready_o(ready),
        .sram_wr_req_o(req), .sram_wr_gnt_i(gnt), .sram_addr_o(addr), .sram_wdata_o(wdata),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n && req && gnt) wr_q.push_back('{addr, wdata, cyc});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [4*OW-1:0] row_data(int k, int r);
        logic [4*OW-1:0] d;
        for (int c = 0; c < 4; c++) d[c*OW +: OW] = OW'(k*16 + r*4 + c + 1);
        return d;
    endfunction

    function automatic logic [16*OW-1:0] tile(int k);
        logic [16*OW-1:0] t;
        for (int r = 0; r < 4; r++) t[r*4*OW +: 4*OW] = row_data(k, r);
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] m, input logic [AW-1:0] n, input logic [AW-1:0] b, output int sc);
        sc = cyc;
        m_size = m;
        n_size = n;
        base = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_tile(input int k, output int acc);
        int n = 0;
        result = tile(k);
        valid = 1'b1;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check("push_timeout", 128'(n < 200), 128'd1);
        acc = cyc;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 300) begin
            tick();
            n++;
        end
        check("done_timeout", 128'(done_cnt != prev), 128'd1);
        tick();
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 128'(ready), 128'd0);
        check({tag, "_req"}, 128'(req), 128'd0);
        check({tag, "_addr"}, 128'(addr), 128'd0);
        check({tag, "_wdata"}, wdata, 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_done"}, 128'(done), 128'd0);
    endtask

    initial begin
        vec_t tbl[16];
        int s, a, dc, acc2, n;
        tbl = '{'{0,0,16'h100}, '{0,1,16'h102}, '{0,2,16'h104}, '{0,3,16'h106},
                '{1,0,16'h101}, '{1,1,16'h103}, '{1,2,16'h105}, '{1,3,16'h107},
                '{2,0,16'h108}, '{2,1,16'h10A}, '{2,2,16'h10C}, '{2,3,16'h10E},
                '{3,0,16'h109}, '{3,1,16'h10B}, '{3,2,16'h10D}, '{3,3,16'h10F}};
        tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        gnt = 1'b1;
        wr_q.delete();
        dc = done_cnt;
        do_start(16'd4, 16'd4, 16'h40, s);
        check("start_busy", 128'(busy), 128'd1);
        check("start_ready", 128'(ready), 128'd1);
        push_tile(0, a);
        wait_done(dc);
        check("single_writes", 128'(wr_q.size()), 128'd4);
        for (int i = 0; i < 4 && i < wr_q.size(); i++) check("single_addr", 128'(wr_q[i].addr), 128'(16'h40 + i));
        if (wr_q.size() >= 4) begin
            check("single_row0", wr_q[0].data, 128'h00000004_00000003_00000002_00000001);
            check("single_done_lat", 128'(done_cyc - wr_q[3].cyc), 128'd1);
        end
        check("single_done_cnt", 128'(done_cnt - dc), 128'd1);

        wr_q.delete();
        dc = done_cnt;
        do_start(16'd8, 16'd8, 16'h100, s);
        push_tile(0, a);
        push_tile(1, a);
        do_start(16'd4, 16'd4, 16'h300, s);
        push_tile(2, a);
        push_tile(3, a);
        wait_done(dc);
        check("grid_writes", 128'(wr_q.size()), 128'd16);
        for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
            check("grid_addr", 128'(wr_q[i].addr), 128'(tbl[i].addr));
            check("grid_data", wr_q[i].data, row_data(tbl[i].k, tbl[i].r));
        end
        check("grid_done_cnt", 128'(done_cnt - dc), 128'd1);

        gnt = 1'b0;
        wr_q.delete();
        dc = done_cnt;
        do_start(16'd8, 16'd8, 16'h20, s);
        push_tile(0, a);
        push_tile(1, a);
        fork
            push_tile(2, acc2);
            begin
                check("full_ready", 128'(ready), 128'd0);
                repeat (5) begin
                    tick();
                    check("stall_req", 128'(req), 128'd1);
                    check("stall_addr", 128'(addr), 128'h20);
                    check("stall_data", wdata, row_data(0, 0));
                end
                gnt = 1'b1;
            end
        join
        push_tile(3, a);
        wait_done(dc);
        check("bp_writes", 128'(wr_q.size()), 128'd16);
        if (wr_q.size() >= 4) check("bp_third_accept", 128'(acc2 - wr_q[3].cyc), 128'd1);

        wr_q.delete();
        dc = done_cnt;
        do_start(16'd0, 16'd8, 16'h0, s);
        wait_done(dc);
        check("zero_writes", 128'(wr_q.size()), 128'd0);
        check("zero_done_lat", 128'(done_cyc - s), 128'd2);

        wr_q.delete();
        dc = done_cnt;
        do_start(16'd4, 16'd4, 16'h40, s);
        push_tile(0, a);
        n = 0;
        while (wr_q.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        check("rst_wait", 128'(wr_q.size() >= 2), 128'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("midrst_no_done", 128'(done_cnt - dc), 128'd0);
        wr_q.delete();
        dc = done_cnt;
        do_start(16'd4, 16'd4, 16'h40, s);
        push_tile(5, a);
        wait_done(dc);
        check("rerun_writes", 128'(wr_q.size()), 128'd4);
        if (wr_q.size() >= 4) begin
            check("rerun_addr", 128'(wr_q[3].addr), 128'h43);
            check("rerun_data", wr_q[3].data, row_data(5, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gemm_result_writer.md
# gemm_result_writer

Output-side drain unit for the 4x4-tile GeMM accelerator. It accepts completed 4x4 result tiles from the GeMM controller/PE array, buffers up to two tiles, and writes them row by row into the output SRAM. Each tile is placed at its row-major position in C, computed from the tile's M/N position. It signals completion once every tile of the (M/4)x(N/4) grid has been written.

## Interface
- AddrWidth, 16, width of sizes, base address and SRAM address
- OutWidth, 32, width of one C element
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  start pulse; sampled only in Idle
- M_size_i  input  AddrWidth  rows of C; tile rows TM = M_size_i>>2
- N_size_i  input  AddrWidth  columns of C; tile cols TN = N_size_i>>2
- base_addr_i  input  AddrWidth  SRAM word address of C[0][0]
- result_valid_i  input  1  tile present on result_i
- result_i  input  16*OutWidth  tile; element (r,c) at bits [(r*4+c)*OutWidth +: OutWidth]
- result_ready_o  output  1  tile accepted when result_valid_i && result_ready_o
- sram_wr_req_o  output  1  write request
- sram_wr_gnt_i  input  1  write accepted this cycle when req && gnt
- sram_addr_o  output  AddrWidth  word address; one word = one tile row
- sram_wdata_o  output  4*OutWidth  row r; element c at bits [c*OutWidth +: OutWidth]
- busy_o  output  1  high in Active and Finish
- done_o  output  1  one-cycle pulse in Finish

## Operation
- **Idle.** When start_i is high, latch TM, TN and base_addr_i; clear the tile counters tm, tn and the row counter r; go to Active.
- **Active, zero-size grid.** If TM==0 or TN==0, go to Finish on the next cycle and perform no writes.
- **Active, draining.**
  - When the FIFO is non-empty, drive sram_wr_req_o=1 with row r of the head tile.
  - sram_addr_o = base + (tm*4 + r)*TN + tn. All arithmetic is modulo 2^AddrWidth; overflow wraps silently.
  - On req&&gnt:
    - If r<3, increment r.
    - If r==3, set r=0, pop the head tile and advance the tile position n-inner/m-outer: tn++, wrapping to 0 with tm++ at tn==TN-1.
  - On the gnt that writes row 3 of tile (TM-1, TN-1), go to Finish.
- **Finish.** done_o=1 for one cycle; the FIFO is flushed; go to Idle.
- **Tile FIFO.**
  - Two entries, registered storage.
  - result_ready_o = (state==Active) && (occupancy<2). It is derived from registered occupancy only, with no combinational path from gnt.
  - When the FIFO is full, a pop and a push cannot occur in the same cycle.
  - A push and a pop in the same cycle are legal at occupancy 1, and occupancy stays at 1.
- **Ignored inputs.**
  - result_valid_i is ignored outside Active, and also in Active while result_ready_o is low.
  - Tiles pushed beyond the TM*TN tiles expected are still accepted while ready is high. They are discarded by the flush in Finish.
  - start_i is ignored in Active and Finish.
- **Output gating.** sram_addr_o and sram_wdata_o are driven to 0 whenever sram_wr_req_o is 0.

## Timing
- **Reset values.** All outputs 0; state Idle; FIFO empty; tm=tn=r=0.
- **Reset mid-operation.** Aborts immediately. In-flight data is lost, no done_o is produced, and the next start_i begins a fresh run.
- **Start.** start_i in cycle t gives state Active, busy_o=1 and result_ready_o=1 in cycle t+1.
- **Write latency.** A tile pushed into an empty FIFO in cycle t gives sram_wr_req_o=1 in cycle t+1.
- **Throughput.** With gnt held high, one row is written per cycle, i.e. 4 cycles per tile, with no bubble between tiles when the FIFO holds a next tile.
- **Stalls.** While req && !gnt, sram_addr_o and sram_wdata_o hold stable and req stays high.
- **Done.** The final gnt is in cycle t; Finish is cycle t+1 with done_o=1 and busy_o=1; Idle is cycle t+2.
- **Zero-size grid.** start_i in cycle t gives done_o=1 in cycle t+2.

## Test plan
- **Single tile.** M=N=4, base=0x40, gnt tied to 1, one tile with element (r,c)=r*4+c+1. Required: 4 writes to 0x40..0x43; first row data {4,3,2,1} (element 0 in the LSBs); done_o pulses exactly one cycle after the 4th gnt.
- **2x2 grid.** M=N=8, base=0x100, four tiles. Required: tile (1,0) row 2 goes to 0x10C; tile (0,1) row 0 goes to 0x101; 16 writes total; done_o after the last.
- **Backpressure.**
  - Hold gnt=0 for 5 cycles during a write. Required: req, addr and data are held stable.
  - Offer 3 tiles back-to-back. Required: the third is held off (ready=0) until the cycle after the first tile's row-3 gnt.
- **Zero size.** M=0, N=8, start_i. Required: no sram_wr_req_o; done_o exactly 2 cycles after start.
- **Reset mid-run.** Assert rst_ni low after 2 rows are written. Required: all outputs 0 at once; a new start with M=N=4 then completes normally.
- **Start while busy.** Pulse start_i with different sizes mid-run. Required: it is ignored; addresses follow the originally latched sizes.
